eca_engine: RTL and testbench
=============================

Name: eca_engine

Overview:
- Parametrised elementary cellular automaton engine.
- Successor to the fixed Rule 110 array: programmable 8-bit Wolfram rule, selectable wrap/zero boundary, and a run controller that advances exactly N generations or free-runs.
- Cell state is read and written in BLOCK_W-wide blocks, with a generation counter and status flags.
- Sits behind the chip pin mux; a host sequences writes, runs and reads through it.

Parameters:
NUM_CELLS, 240, number of automaton cells (>= 3)
BLOCK_W, 8, cells per read/write block
ADDR_W, 5, block address width (2^ADDR_W*BLOCK_W >= NUM_CELLS)
CNT_W, 16, width of step_count and gen_count
DEFAULT_RULE, 110, rule number loaded at reset
SEED_INDEX, 0, index of the single live cell at reset

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
rule_wr  in  1  load rule_in into the rule register
rule_in  in  8  Wolfram rule number
wrap_mode  in  1  1 = wrap-around boundary, 0 = zero-padded boundary
wr_en  in  1  write wr_data into block addr
addr  in  ADDR_W  block address for read and write
wr_data  in  BLOCK_W  block write data; bit j maps to cell addr*BLOCK_W+j
rd_data  out  BLOCK_W  registered read of the current-state block at addr
start  in  1  begin a run of step_count generations
step_count  in  CNT_W  generations to run, sampled on start
free_run  in  1  step continuously while high
halt  in  1  pause stepping
busy  out  1  run in progress (RUN or FREE)
done  out  1  one-cycle pulse when a RUN completes
gen_count  out  CNT_W  generations executed since reset
all_zero  out  1  all current cells are 0

Behaviour:
- Reset values: cells = only SEED_INDEX set; rule = DEFAULT_RULE; FSM = IDLE; gen_count = 0; remaining = 0; rd_data = 0; busy = 0; done = 0.
- Step: new[i] = rule[{L,C,R}], where L = cell[i+1], C = cell[i], R = cell[i-1]. All cells update simultaneously from the old state at one clk edge.
- Boundaries:
  - wrap_mode = 1: L of cell NUM_CELLS-1 is cell 0; R of cell 0 is cell NUM_CELLS-1.
  - wrap_mode = 0: out-of-range neighbours read 0.
  - wrap_mode is sampled per step.
- Step enable: FSM in RUN or FREE, halt = 0 and wr_en = 0. A write always wins and stalls that cycle's step; the stalled step is neither lost nor counted.
- Each step increments gen_count, which wraps modulo 2^CNT_W.
- Write: cells addr*BLOCK_W .. +BLOCK_W-1 take wr_data at the edge. Bits beyond NUM_CELLS-1 are dropped; blocks wholly out of range are ignored.
- Read: rd_data is updated every cycle with the current-state block at addr (1-cycle latency). Out-of-range bits read 0. A step or write becomes visible on rd_data one cycle after it.
- Rule: rule_wr loads rule_in at the edge. A step on that same edge uses the old rule.
- FSM:
  - IDLE, start, step_count = 0: done = 1 next cycle; no step; stay IDLE.
  - IDLE, start, step_count = N > 0: remaining = N, go to RUN.
  - IDLE, free_run = 1, start = 0: go to FREE. start has priority over free_run.
  - RUN: each enabled step decrements remaining. On the step that makes remaining 0, go to IDLE and assert done for the following cycle.
  - FREE: step every enabled cycle. Return to IDLE when free_run = 0 (no done pulse).
  - start is ignored while busy.
- busy = (FSM != IDLE).
- Uninterrupted RUN of N: busy high for exactly N cycles; done coincides with the first busy-low cycle.
- all_zero is combinational from the current cells.
- Reset mid-run: everything returns to reset values; no done pulse.

Test Plan:
1. Reset, wrap_mode = 0, start with N = 3 -> busy 3 cycles, then done for 1 cycle; rd_data(addr 0) steps 0x01 -> 0x03 -> 0x07 -> 0x0D; gen_count = 3.
2. rule_wr with 90, write block 0 = 0x10 (others 0), start N = 1 -> block 0 = 0x28.
3. Rule 90, block 0 = 0x01, wrap_mode = 1, N = 1 -> block 0 = 0x02, block 29 = 0x80. Repeat with wrap_mode = 0 -> block 29 = 0x00.
4. RUN N = 5 with halt high 2 cycles and one wr_en mid-run -> busy 8 cycles, gen_count +5, written block then evolves.
5. start with step_count = 0 -> done next cycle, gen_count unchanged. Second start while busy -> ignored. Rule 0, N = 1 -> all_zero = 1.
6. FREE for 10 cycles, then assert reset during a RUN -> busy = 0, done never pulses, block 0 = 0x01, rule 110 restored, gen_count = 0.

Source files
------------

// File: rtl/eca_engine_if.sv
// Host-side bus of the cellular automaton engine: configuration, block access,
// run control and status, bundled for the pin-mux boundary.
interface eca_engine_if #(
  parameter int ADDR_W  = 5,
  parameter int BLOCK_W = 8,
  parameter int CNT_W   = 16
);
  logic               rule_wr;
  logic [7:0]         rule_in;
  logic               wrap_mode;
  logic               wr_en;
  logic [ADDR_W-1:0]  addr;
  logic [BLOCK_W-1:0] wr_data;
  logic [BLOCK_W-1:0] rd_data;
  logic               start;
  logic [CNT_W-1:0]   step_count;
  logic               free_run;
  logic               halt;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   gen_count;
  logic               all_zero;

  modport master (
    output rule_wr, rule_in, wrap_mode, wr_en, addr, wr_data,
           start, step_count, free_run, halt,
    input  rd_data, busy, done, gen_count, all_zero
  );

  modport slave (
    input  rule_wr, rule_in, wrap_mode, wr_en, addr, wr_data,
           start, step_count, free_run, halt,
    output rd_data, busy, done, gen_count, all_zero
  );
endinterface

// File: rtl/eca_engine.sv
// Elementary cellular automaton with programmable rule, wrap/zero boundary,
// block-wise cell access and an N-step / free-running run controller.
//
// state | meaning
// IDLE  | no stepping; accepts start / free_run
// RUN   | stepping until the sampled step count is exhausted
// FREE  | stepping while free_run stays high
module eca_engine #(
  parameter int NUM_CELLS    = 240,
  parameter int BLOCK_W      = 8,
  parameter int ADDR_W       = 5,
  parameter int CNT_W        = 16,
  parameter int DEFAULT_RULE = 110,
  parameter int SEED_INDEX   = 0
) (
  input logic        clk,
  input logic        reset,
  eca_engine_if.slave bus
);

  localparam int TOTAL  = (1 << ADDR_W) * BLOCK_W;
  localparam int BASE_W = $clog2(TOTAL);
  localparam logic [NUM_CELLS-1:0] SEED = {{(NUM_CELLS-1){1'b0}}, 1'b1} << SEED_INDEX;

  typedef enum logic [1:0] {IDLE, RUN, FREE} state_t;

  state_t               state;
  logic [NUM_CELLS-1:0] cells;
  logic [NUM_CELLS-1:0] next_cells;
  logic [7:0]           rule_reg;
  logic [CNT_W-1:0]     remaining;
  logic [CNT_W-1:0]     gen_count;
  logic                 busy_r;
  logic                 done_r;
  logic [BLOCK_W-1:0]   rd_data_r;
  logic [TOTAL-1:0]     cells_pad;
  logic [TOTAL-1:0]     wr_pad;
  logic [BASE_W-1:0]    base;
  logic                 step_en;

  assign base    = BASE_W'(int'(bus.addr) * BLOCK_W);
  assign step_en = (state != IDLE) && !bus.halt && !bus.wr_en;

  // Padding to the full address space makes out-of-range bits read 0 and
  // silently drops writes that land beyond the last cell.
  always_comb begin
    cells_pad                  = '0;
    cells_pad[NUM_CELLS-1:0]   = cells;
    wr_pad                     = cells_pad;
    wr_pad[base +: BLOCK_W]    = bus.wr_data;
  end

  for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
    logic l;
    logic r;
    if (i == NUM_CELLS-1) begin : g_left_edge
      assign l = bus.wrap_mode & cells[0];
    end else begin : g_left_mid
      assign l = cells[i+1];
    end
    if (i == 0) begin : g_right_edge
      assign r = bus.wrap_mode & cells[NUM_CELLS-1];
    end else begin : g_right_mid
      assign r = cells[i-1];
    end
    assign next_cells[i] = rule_reg[{l, cells[i], r}];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cells     <= SEED;
      rule_reg  <= 8'(DEFAULT_RULE);
      remaining <= '0;
      gen_count <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      rd_data_r <= '0;
    end else begin
      done_r    <= 1'b0;
      rd_data_r <= cells_pad[base +: BLOCK_W];

      if (bus.rule_wr) rule_reg <= bus.rule_in;

      if (bus.wr_en) begin
        cells <= wr_pad[NUM_CELLS-1:0];
      end else if (step_en) begin
        cells     <= next_cells;
        gen_count <= gen_count + 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.step_count == '0) begin
              done_r <= 1'b1;
            end else begin
              remaining <= bus.step_count;
              state     <= RUN;
              busy_r    <= 1'b1;
            end
          end else if (bus.free_run) begin
            state  <= FREE;
            busy_r <= 1'b1;
          end
        end
        RUN: begin
          if (step_en) begin
            remaining <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) begin
              state  <= IDLE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end
          end
        end
        FREE: begin
          if (!bus.free_run) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_data   = rd_data_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.gen_count = gen_count;
  assign bus.all_zero  = ~|cells;

endmodule

// File: tb/tb_eca_engine.sv
// Directed bench for eca_engine: hand-computed rule 110 / rule 90 evolutions,
// boundary modes, halt/write stalls, run-control corner cases and reset.
module tb_eca_engine;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc;
  logic done_seen;

  always #5 clk = ~clk;

  eca_engine_if #(.ADDR_W(5), .BLOCK_W(8), .CNT_W(16)) bus ();

  eca_engine #(
    .NUM_CELLS(240), .BLOCK_W(8), .ADDR_W(5), .CNT_W(16),
    .DEFAULT_RULE(110), .SEED_INDEX(0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic read_blk(input logic [4:0] a, input logic [7:0] exp, input string tag);
    bus.addr = a;
    tick();
    chk(tag, 32'(bus.rd_data), 32'(exp));
  endtask

  task automatic write_blk(input logic [4:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.addr = a; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic set_rule(input logic [7:0] r);
    bus.rule_wr = 1'b1; bus.rule_in = r;
    tick();
    bus.rule_wr = 1'b0;
  endtask

  // Starts a run and counts busy cycles; done is sampled on the first idle cycle.
  task automatic run_n(input logic [15:0] n, output int busy_cycles, output logic done_at_end);
    bus.start = 1'b1; bus.step_count = n;
    tick();
    bus.start = 1'b0;
    busy_cycles = 0;
    while (bus.busy === 1'b1 && busy_cycles < 200) begin
      busy_cycles++;
      tick();
    end
    done_at_end = bus.done;
  endtask

  initial begin
    reset = 1'b1;
    bus.rule_wr = 0; bus.rule_in = 0; bus.wrap_mode = 0; bus.wr_en = 0;
    bus.addr = 0; bus.wr_data = 0; bus.start = 0; bus.step_count = 0;
    bus.free_run = 0; bus.halt = 0;
    tick(); tick();
    reset = 1'b0;
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_done", 32'(bus.done), 0);
    chk("reset_gen", 32'(bus.gen_count), 0);
    chk("reset_rd", 32'(bus.rd_data), 0);
    chk("reset_all_zero", 32'(bus.all_zero), 0);

    // 1: rule 110, zero boundary, N=3, watching rd_data lag by one cycle
    bus.start = 1'b1; bus.step_count = 3; bus.addr = 0;
    tick();
    bus.start = 1'b0;
    chk("t1_busy_c1", 32'(bus.busy), 1);
    chk("t1_rd_0", 32'(bus.rd_data), 32'h01);
    tick();
    chk("t1_busy_c2", 32'(bus.busy), 1);
    chk("t1_done_c2", 32'(bus.done), 0);
    tick();
    chk("t1_busy_c3", 32'(bus.busy), 1);
    chk("t1_rd_1", 32'(bus.rd_data), 32'h03);
    tick();
    chk("t1_busy_low", 32'(bus.busy), 0);
    chk("t1_done", 32'(bus.done), 1);
    chk("t1_rd_2", 32'(bus.rd_data), 32'h07);
    chk("t1_gen", 32'(bus.gen_count), 3);
    tick();
    chk("t1_rd_3", 32'(bus.rd_data), 32'h0D);
    chk("t1_done_clr", 32'(bus.done), 0);

    // 2: rule 90 from a single cell 4
    set_rule(8'd90);
    write_blk(0, 8'h10);
    run_n(1, cyc, done_seen);
    chk("t2_busy_cycles", 32'(cyc), 1);
    chk("t2_done", 32'(done_seen), 1);
    read_blk(0, 8'h28, "t2_blk0");

    // 3: wrap vs zero boundary at cell 0
    write_blk(0, 8'h01);
    bus.wrap_mode = 1'b1;
    run_n(1, cyc, done_seen);
    read_blk(0, 8'h02, "t3_wrap_blk0");
    read_blk(29, 8'h80, "t3_wrap_blk29");
    write_blk(0, 8'h01);
    write_blk(29, 8'h00);
    bus.wrap_mode = 1'b0;
    run_n(1, cyc, done_seen);
    read_blk(29, 8'h00, "t3_zero_blk29");
    read_blk(0, 8'h02, "t3_zero_blk0");
    chk("t3_gen", 32'(bus.gen_count), 6);

    // 4: N=5 with two halt cycles and one write stall
    write_blk(0, 8'h01);
    bus.start = 1'b1; bus.step_count = 5;
    tick();
    bus.start = 1'b0;
    cyc = 1;
    bus.halt = 1'b1;
    tick(); cyc += int'(bus.busy);
    tick(); cyc += int'(bus.busy);
    bus.halt = 1'b0;
    tick(); cyc += int'(bus.busy);
    bus.wr_en = 1'b1; bus.addr = 10; bus.wr_data = 8'h18;
    tick(); cyc += int'(bus.busy);
    bus.wr_en = 1'b0;
    while (bus.busy === 1'b1 && cyc < 200) begin
      tick();
      cyc += int'(bus.busy);
    end
    chk("t4_busy_cycles", 32'(cyc), 8);
    chk("t4_done", 32'(bus.done), 1);
    chk("t4_gen", 32'(bus.gen_count), 11);
    read_blk(10, 8'h81, "t4_blk10");
    read_blk(9, 8'h80, "t4_blk9");
    read_blk(0, 8'h22, "t4_blk0");

    // 5: zero-length run, ignored restart, rule 0
    bus.start = 1'b1; bus.step_count = 0;
    tick();
    bus.start = 1'b0;
    chk("t5_zero_done", 32'(bus.done), 1);
    chk("t5_zero_busy", 32'(bus.busy), 0);
    chk("t5_zero_gen", 32'(bus.gen_count), 11);
    tick();
    chk("t5_zero_done_clr", 32'(bus.done), 0);
    bus.start = 1'b1; bus.step_count = 3;
    tick();
    bus.step_count = 7;
    tick(); tick();
    bus.start = 1'b0;
    tick();
    chk("t5_restart_busy", 32'(bus.busy), 0);
    chk("t5_restart_done", 32'(bus.done), 1);
    chk("t5_restart_gen", 32'(bus.gen_count), 14);
    chk("t5_not_zero", 32'(bus.all_zero), 0);
    set_rule(8'd0);
    run_n(1, cyc, done_seen);
    chk("t5_all_zero", 32'(bus.all_zero), 1);
    chk("t5_gen", 32'(bus.gen_count), 15);

    // 6: free run for 10 cycles, then reset in the middle of a run
    set_rule(8'd90);
    write_blk(0, 8'h01);
    bus.free_run = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("t6_free_busy", 32'(bus.busy), 1);
    bus.free_run = 1'b0;
    tick();
    chk("t6_free_exit", 32'(bus.busy), 0);
    chk("t6_free_nodone", 32'(bus.done), 0);
    chk("t6_free_gen", 32'(bus.gen_count), 25);
    bus.start = 1'b1; bus.step_count = 20;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_busy", 32'(bus.busy), 0);
    chk("t6_rst_done", 32'(bus.done), 0);
    chk("t6_rst_gen", 32'(bus.gen_count), 0);
    read_blk(0, 8'h01, "t6_rst_blk0");
    chk("t6_rst_done_later", 32'(bus.done), 0);
    run_n(1, cyc, done_seen);
    read_blk(0, 8'h03, "t6_rule110_restored");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
